// File: rtl/pcpi_systolic_mac.sv
// PicoRV32 PCPI coprocessor: N x N output-stationary systolic MAC computing
// C = bias + A*B on signed operands, returning C or a per-element threshold mask.
module pcpi_systolic_mac #(
    parameter int unsigned N           = 3,
    parameter int unsigned DW          = 16,
    parameter int unsigned AW          = 32,
    parameter int          THRESH_INIT = -70
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready
);
    localparam int unsigned NN     = N * N;
    localparam int unsigned IW     = $clog2(NN);
    localparam int unsigned PW     = 2 * DW;
    localparam int unsigned T_LAST = 3 * N - 3;
    localparam int unsigned TW     = $clog2(3 * N);

    localparam logic [2:0] F3_LOAD  = 3'b000;
    localparam logic [2:0] F3_READC = 3'b010;
    localparam logic [2:0] F3_MASK  = 3'b011;
    localparam logic [2:0] F3_CLEAR = 3'b101;
    localparam logic [2:0] F3_START = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_RESPOND, S_HOLD} state_t;

    state_t state_q, state_d;
    logic [TW-1:0] t_q, t_d;
    logic ready_d, wr_d, wait_d;
    logic [31:0] rd_d;

    logic signed [DW-1:0] a_q    [NN];
    logic signed [DW-1:0] b_q    [NN];
    logic signed [DW-1:0] bias_q [NN];
    logic signed [DW-1:0] thr_q;
    logic signed [AW-1:0] c_q    [NN];
    logic signed [AW-1:0] c_d    [NN];
    logic signed [AW-1:0] thr_ext;
    logic signed [AW-1:0] acc;
    logic signed [PW-1:0] prod;
    logic [31:0] mask_cur, mask_nxt;

    logic [2:0]    funct3;
    logic          matched, accept;
    logic [7:0]    addr;
    logic [IW-1:0] idx_a, idx_b, idx_bias;
    logic          unused_bits;

    assign funct3      = pcpi_insn[14:12];
    assign matched     = (pcpi_insn[6:0] == 7'b0001011) &&
                         (funct3 inside {F3_LOAD, F3_READC, F3_MASK, F3_CLEAR, F3_START});
    assign accept      = pcpi_valid && matched && (state_q == S_IDLE);
    assign addr        = pcpi_rs1[7:0];
    assign idx_a       = IW'(addr);
    assign idx_b       = IW'(addr - 8'(NN));
    assign idx_bias    = IW'(addr - 8'(2 * NN));
    assign thr_ext     = AW'(thr_q);
    assign unused_bits = ^{pcpi_insn[31:15], pcpi_insn[11:7], pcpi_rs2[31:DW]};

    // Skewed systolic step: PE(i,j) consumes A[i][k]*B[k][j] at t = i+j+k
    always_comb begin
        c_d  = c_q;
        acc  = '0;
        prod = '0;
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
                acc = (t_q == '0) ? AW'(bias_q[i*N+j]) : c_q[i*N+j];
                for (int unsigned k = 0; k < N; k++) begin
                    if (32'(t_q) == i + j + k) begin
                        prod = PW'(a_q[i*N+k]) * PW'(b_q[k*N+j]);
                        acc  = acc + AW'(prod);
                    end
                end
                c_d[i*N+j] = acc;
            end
        end
    end

    // Threshold masks over the current and the about-to-be-written accumulators
    always_comb begin
        mask_cur = '0;
        mask_nxt = '0;
        for (int unsigned e = 0; e < NN; e++) begin
            mask_cur[e] = (c_q[e] >= thr_ext);
            mask_nxt[e] = (c_d[e] >= thr_ext);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            t_q        <= '0;
            pcpi_ready <= 1'b0;
            pcpi_wr    <= 1'b0;
            pcpi_wait  <= 1'b0;
            pcpi_rd    <= '0;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            pcpi_ready <= ready_d;
            pcpi_wr    <= wr_d;
            pcpi_wait  <= wait_d;
            pcpi_rd    <= rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        ready_d = 1'b0;
        wr_d    = 1'b0;
        wait_d  = 1'b0;
        rd_d    = '0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (funct3 == F3_START) begin
                        state_d = S_COMPUTE;
                        t_d     = '0;
                        wait_d  = 1'b1;
                    end else begin
                        state_d = S_RESPOND;
                        ready_d = 1'b1;
                        if (funct3 == F3_READC) begin
                            wr_d = 1'b1;
                            if (pcpi_rs1 < 32'(NN)) rd_d = 32'(c_q[pcpi_rs1[IW-1:0]]);
                        end else if (funct3 == F3_MASK) begin
                            wr_d = 1'b1;
                            rd_d = mask_cur;
                        end
                    end
                end
            end
            S_COMPUTE: begin
                if (t_q == TW'(T_LAST)) begin
                    state_d = S_RESPOND;
                    ready_d = 1'b1;
                    wr_d    = 1'b1;
                    rd_d    = mask_nxt;
                end else begin
                    t_d    = t_q + TW'(1);
                    wait_d = 1'b1;
                end
            end
            S_RESPOND: state_d = S_HOLD;
            S_HOLD:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Operand/accumulator register file
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned e = 0; e < NN; e++) begin
                a_q[e]    <= '0;
                b_q[e]    <= '0;
                bias_q[e] <= '0;
                c_q[e]    <= '0;
            end
            thr_q <= DW'(THRESH_INIT);
        end else if (accept && (funct3 == F3_CLEAR)) begin
            for (int unsigned e = 0; e < NN; e++) begin
                a_q[e]    <= '0;
                b_q[e]    <= '0;
                bias_q[e] <= '0;
                c_q[e]    <= '0;
            end
        end else if (accept && (funct3 == F3_LOAD)) begin
            if (addr < 8'(NN))                a_q[idx_a]       <= pcpi_rs2[DW-1:0];
            else if (addr < 8'(2 * NN))       b_q[idx_b]       <= pcpi_rs2[DW-1:0];
            else if (addr < 8'(3 * NN))       bias_q[idx_bias] <= pcpi_rs2[DW-1:0];
            else if (addr == 8'(3 * NN))      thr_q            <= pcpi_rs2[DW-1:0];
        end else if (state_q == S_COMPUTE) begin
            for (int unsigned e = 0; e < NN; e++) c_q[e] <= c_d[e];
        end
    end
endmodule
